// File: rtl/wiring_enum_pkg.sv
// -----------------------------------------------------------------------------
// cmt_wiring_pkg
// Shared types and helpers for the wiring-predicate enumerator.
//   wiring_state_t    : enumerator FSM states
//   wiring_tuple_t    : one streamed gate record, fields sized for the widest
//                       supported gate index (GATE_W); users truncate to LN_G
//   butterfly_partner : second input gate of a butterfly wiring, parametrised
//                       at the call site by ln_g
// -----------------------------------------------------------------------------
package cmt_wiring_pkg;

  localparam int unsigned GATE_W  = 16;  // widest supported gate index
  localparam int unsigned LAYER_W = 4;   // widest supported layer index

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wiring_state_t;

  typedef struct packed {
    logic [GATE_W-1:0] gate;
    logic [GATE_W-1:0] in0;
    logic [GATE_W-1:0] in1;
    logic              isAdd;
    logic              isMul;
    logic              last;
  } wiring_tuple_t;

  // g XOR (1 << (layer mod ln_g)). The mod is a bounded chain of
  // compare/subtract steps so no divider is inferred.
  function automatic logic [GATE_W-1:0] butterfly_partner(
    input logic [GATE_W-1:0]  g,
    input logic [LAYER_W-1:0] layer,
    input int unsigned        ln_g
  );
    logic [LAYER_W-1:0] m;
    logic [GATE_W-1:0]  bit_sel;
    m = layer;
    for (int i = 0; i < (1 << LAYER_W); i++) begin
      if (32'(m) >= ln_g) m = m - LAYER_W'(ln_g);
    end
    bit_sel = GATE_W'(1) << m;
    return g ^ bit_sel;
  endfunction

endpackage

// File: rtl/wiring_enum_if.sv
// -----------------------------------------------------------------------------
// wiring_enum_if
// Control and tuple-stream signals of the wiring enumerator.
//   start/startLayer      : enumeration request and layer number
//   busy/err/done         : status (err and done are one-cycle pulses)
//   outValid/outReady     : stream handshake
//   outGate/outIn0/outIn1 : gate index and its two input gates in layer L+1
//   outIsAdd/outIsMul     : gate type
//   outLast               : tuple is the last gate of the layer
// master = enumerator side, slave = requester/consumer side.
// -----------------------------------------------------------------------------
interface wiring_enum_if #(
  parameter int LN_G     = 3,
  parameter int LN_LAYER = 2
);
  logic                start;
  logic [LN_LAYER-1:0] startLayer;
  logic                busy;
  logic                err;
  logic                outValid;
  logic                outReady;
  logic [LN_G-1:0]     outGate;
  logic [LN_G-1:0]     outIn0;
  logic [LN_G-1:0]     outIn1;
  logic                outIsAdd;
  logic                outIsMul;
  logic                outLast;
  logic                done;

  modport master (
    input  start, startLayer, outReady,
    output busy, err, outValid, outGate, outIn0, outIn1,
           outIsAdd, outIsMul, outLast, done
  );

  modport slave (
    output start, startLayer, outReady,
    input  busy, err, outValid, outGate, outIn0, outIn1,
           outIsAdd, outIsMul, outLast, done
  );
endinterface

// File: rtl/wiring_enum_rule.sv
// -----------------------------------------------------------------------------
// wiring_rule
// Combinational wiring predicate for one gate: (layer, gate) -> in0, in1, type.
//   layer  : layer index
//   gate   : gate index within the layer
//   in0    : first input gate  (= gate)
//   in1    : second input gate (butterfly partner)
//   is_add : additive gate
//   is_mul : multiplicative gate
// Macro WIRING_MUL_EN: when defined, odd layers are multiplicative; when
// undefined every layer is additive and no mul-type logic exists.
// -----------------------------------------------------------------------------
module wiring_rule
  import cmt_wiring_pkg::*;
#(
  parameter int LN_G     = 3,
  parameter int LN_LAYER = 2
) (
  input  logic [LN_LAYER-1:0] layer,
  input  logic [LN_G-1:0]     gate,
  output logic [LN_G-1:0]     in0,
  output logic [LN_G-1:0]     in1,
  output logic                is_add,
  output logic                is_mul
);

  assign in0 = gate;
  // Truncation drops any carry out of the LN_G-bit index space.
  assign in1 = LN_G'(butterfly_partner(GATE_W'(gate), LAYER_W'(layer), LN_G));

`ifdef WIRING_MUL_EN
  assign is_mul = layer[0];
  assign is_add = ~layer[0];
`else
  assign is_add = 1'b1;
  assign is_mul = 1'b0;
`endif

endmodule

// File: rtl/wiring_enum.sv
// -----------------------------------------------------------------------------
// wiring_enum
// Streams every gate of a requested layer as {gate, in0, in1, type, last}
// over a valid/ready handshake, one tuple per cycle when not back-pressured.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : wiring_enum_if master port (request, status and tuple stream)
// Macro WIRING_MUL_EN selects odd layers as multiplicative (see wiring_rule).
//
// state | meaning
// IDLE  | waiting for start; illegal layer pulses err
// RUN   | presenting tuples; counter advances on each handshake
// DONE  | done pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module wiring_enum
  import cmt_wiring_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int LN_G       = 3,
  parameter int LN_LAYER   = $clog2(NUM_LAYERS)
) (
  input  logic          clk,
  input  logic          rst_n,
  wiring_enum_if.master bus
);

  localparam int G = 1 << LN_G;
  localparam logic [LN_LAYER-1:0] LAST_LAYER = LN_LAYER'(NUM_LAYERS - 1);

  wiring_state_t       state_q, state_d;
  logic [LN_G-1:0]     cnt_q, cnt_d;
  logic [LN_LAYER-1:0] layer_q, layer_d;
  wiring_tuple_t       tuple_q, tuple_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [LN_LAYER-1:0] rule_layer;
  logic [LN_G-1:0]     rule_gate;
  logic [LN_G-1:0]     rule_in0, rule_in1;
  logic                rule_add, rule_mul;
  wiring_tuple_t       rule_tuple;

  // The rule looks at the gate that will be presented next, so its result
  // can be registered straight into the output tuple.
  always_comb begin
    rule_layer = layer_q;
    rule_gate  = cnt_q + LN_G'(1);
    if (state_q == IDLE) begin
      rule_layer = bus.startLayer;
      rule_gate  = '0;
    end
  end

  wiring_rule #(
    .LN_G     (LN_G),
    .LN_LAYER (LN_LAYER)
  ) u_rule (
    .layer  (rule_layer),
    .gate   (rule_gate),
    .in0    (rule_in0),
    .in1    (rule_in1),
    .is_add (rule_add),
    .is_mul (rule_mul)
  );

  always_comb begin
    rule_tuple       = '0;
    rule_tuple.gate  = GATE_W'(rule_gate);
    rule_tuple.in0   = GATE_W'(rule_in0);
    rule_tuple.in1   = GATE_W'(rule_in1);
    rule_tuple.isAdd = rule_add;
    rule_tuple.isMul = rule_mul;
    rule_tuple.last  = (rule_gate == LN_G'(G - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    tuple_d = tuple_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.startLayer < LAST_LAYER) begin
            state_d = RUN;
            layer_d = bus.startLayer;
            cnt_d   = '0;
            tuple_d = rule_tuple;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.outReady) begin
          if (tuple_q.last) begin
            state_d = DONE;
            tuple_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + LN_G'(1);
            tuple_d = rule_tuple;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      layer_q <= '0;
      tuple_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      tuple_q <= tuple_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.outValid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.done     = done_q;
  assign bus.outGate  = LN_G'(tuple_q.gate);
  assign bus.outIn0   = LN_G'(tuple_q.in0);
  assign bus.outIn1   = LN_G'(tuple_q.in1);
  assign bus.outIsAdd = tuple_q.isAdd;
  assign bus.outIsMul = tuple_q.isMul;
  assign bus.outLast  = tuple_q.last;

endmodule

// File: tb/tb_wiring_enum.sv
// Self-checking bench for wiring_enum (LN_G=3, NUM_LAYERS=4).
module tb_wiring_enum;

  localparam int NUM_LAYERS = 4;
  localparam int LN_G       = 3;
  localparam int LN_LAYER   = 2;
  localparam int G          = 8;

  logic clk;
  logic rst_n;

  wiring_enum_if #(.LN_G(LN_G), .LN_LAYER(LN_LAYER)) bus ();

  wiring_enum #(
    .NUM_LAYERS (NUM_LAYERS),
    .LN_G       (LN_G),
    .LN_LAYER   (LN_LAYER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_add(input int layer);
`ifdef WIRING_MUL_EN
    return (layer % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  function automatic int exp_mul(input int layer);
`ifdef WIRING_MUL_EN
    return (layer % 2 == 1) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int ref_in1(input int layer, input int g);
    return (g ^ (1 << (layer % LN_G))) % G;
  endfunction

  task automatic check_tuple(input string name, input int layer, input int g, input int in1);
    check({name, "_valid"}, int'(bus.outValid), 1);
    check({name, "_busy"},  int'(bus.busy), 1);
    check({name, "_gate"},  int'(bus.outGate), g);
    check({name, "_in0"},   int'(bus.outIn0), g);
    check({name, "_in1"},   int'(bus.outIn1), in1);
    check({name, "_add"},   int'(bus.outIsAdd), exp_add(layer));
    check({name, "_mul"},   int'(bus.outIsMul), exp_mul(layer));
    check({name, "_last"},  int'(bus.outLast), (g == G - 1) ? 1 : 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, int'(bus.outValid), 0);
    check({name, "_busy"},  int'(bus.busy), 0);
    check({name, "_err"},   int'(bus.err), 0);
    check({name, "_done"},  int'(bus.done), 0);
    check({name, "_gate"},  int'(bus.outGate), 0);
    check({name, "_in0"},   int'(bus.outIn0), 0);
    check({name, "_in1"},   int'(bus.outIn1), 0);
    check({name, "_add"},   int'(bus.outIsAdd), 0);
    check({name, "_mul"},   int'(bus.outIsMul), 0);
    check({name, "_last"},  int'(bus.outLast), 0);
  endtask

  // Run the current stream to its done pulse (bounded), then step into IDLE.
  task automatic drain(input string name);
    bit seen;
    seen = 1'b0;
    bus.outReady = 1'b1;
    for (int i = 0; i < 4 * G && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check({name, "_drain_done"}, int'(seen), 1);
    tick();
  endtask

  task automatic do_start(input int layer);
    bus.startLayer = LN_LAYER'(layer);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  typedef struct {
    int layer;
    int in1 [G];
  } vec_t;

  vec_t vecs [3];

  initial begin
    int eg, vcnt, stalls;
    bit fin, hs;
    int q[$];
    int m_layer, g, l;
    bit m_done, m_err, ev, s, r, nd, ne;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eg, vcnt, stalls;
    bit fin, hs;
    int q[$];
    int m_layer, g, l;
    bit m_done, m_err, ev, s, r, nd, ne;

    vecs[0].layer = 0; vecs[0].in1 = '{1, 0, 3, 2, 5, 4, 7, 6};
    vecs[1].layer = 1; vecs[1].in1 = '{2, 3, 0, 1, 6, 7, 4, 5};
    vecs[2].layer = 2; vecs[2].in1 = '{4, 5, 6, 7, 0, 1, 2, 3};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.startLayer = '0;
    bus.outReady   = 1'b0;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full-rate streams for layers 0..2.
    for (int v = 0; v < 3; v++) begin
      bus.outReady = 1'b1;
      do_start(vecs[v].layer);
      for (int gi = 0; gi < G; gi++) begin
        check_tuple($sformatf("tab_L%0d_g%0d", vecs[v].layer, gi), vecs[v].layer, gi, vecs[v].in1[gi]);
        check($sformatf("tab_L%0d_g%0d_done", vecs[v].layer, gi), int'(bus.done), 0);
        tick();
      end
      check($sformatf("tab_L%0d_done", vecs[v].layer), int'(bus.done), 1);
      check($sformatf("tab_L%0d_busy_end", vecs[v].layer), int'(bus.busy), 0);
      check($sformatf("tab_L%0d_valid_end", vecs[v].layer), int'(bus.outValid), 0);
      tick();
      check($sformatf("tab_L%0d_done_pulse", vecs[v].layer), int'(bus.done), 0);
    end

    // Back-pressure: three stall cycles while g=2 of layer 2 is presented.
    bus.outReady = 1'b1;
    do_start(2);
    eg = 0; vcnt = 0; stalls = 0; fin = 1'b0;
    for (int c = 0; c < 30 && !fin; c++) begin
      if (bus.done) begin
        fin = 1'b1;
      end else begin
        if (bus.outValid) begin
          vcnt++;
          check($sformatf("bp_c%0d_gate", c), int'(bus.outGate), eg);
          check($sformatf("bp_c%0d_in0", c), int'(bus.outIn0), eg);
          check($sformatf("bp_c%0d_in1", c), int'(bus.outIn1), ref_in1(2, eg));
          check($sformatf("bp_c%0d_add", c), int'(bus.outIsAdd), exp_add(2));
          if (eg == 2 && stalls < 3) begin
            bus.outReady = 1'b0;
            stalls++;
          end else begin
            bus.outReady = 1'b1;
          end
        end
        hs = bus.outValid && bus.outReady;
        tick();
        if (hs) eg++;
      end
    end
    check("bp_finished", int'(fin), 1);
    check("bp_valid_cycles", vcnt, 11);
    check("bp_tuples", eg, G);
    bus.outReady = 1'b1;
    tick();

    // Illegal layer, then a legal start on the very next cycle.
    bus.startLayer = LN_LAYER'(3);
    bus.start      = 1'b1;
    tick();
    check("ill_err", int'(bus.err), 1);
    check("ill_valid", int'(bus.outValid), 0);
    check("ill_busy", int'(bus.busy), 0);
    bus.startLayer = LN_LAYER'(1);
    tick();
    bus.start = 1'b0;
    check("ill_err_pulse", int'(bus.err), 0);
    check_tuple("ill_next", 1, 0, 2);
    drain("ill_next");

    // Reset in the middle of a layer-0 stream, then restart on layer 1.
    bus.outReady = 1'b1;
    do_start(0);
    for (int i = 0; i < 4; i++) tick();
    check("mid_gate_before", int'(bus.outGate), 4);
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_post%0d_done", i), int'(bus.done), 0);
      check($sformatf("mid_post%0d_valid", i), int'(bus.outValid), 0);
    end
    do_start(1);
    check_tuple("mid_restart_g0", 1, 0, 2);
    tick();
    check_tuple("mid_restart_g1", 1, 1, 3);
    drain("mid_restart");

    // Start requests inside a run are ignored.
    bus.outReady = 1'b1;
    do_start(0);
    for (int i = 0; i < 5; i++) tick();
    check_tuple("ign_g5", 0, 5, 4);
    bus.startLayer = LN_LAYER'(2);
    bus.start      = 1'b1;
    tick();
    check_tuple("ign_g6", 0, 6, 7);
    check("ign_g6_err", int'(bus.err), 0);
    bus.startLayer = LN_LAYER'(3);
    tick();
    bus.start = 1'b0;
    check_tuple("ign_g7", 0, 7, 6);
    check("ign_g7_err", int'(bus.err), 0);
    tick();
    check("ign_done", int'(bus.done), 1);
    check("ign_done_err", int'(bus.err), 0);
    tick();
    check("ign_idle_valid", int'(bus.outValid), 0);

    // Randomised traffic against a queue-based reference.
    m_layer = 0; m_done = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ev = (q.size() > 0);
      check($sformatf("rnd%0d_valid", c), int'(bus.outValid), int'(ev));
      check($sformatf("rnd%0d_busy", c), int'(bus.busy), int'(ev));
      check($sformatf("rnd%0d_done", c), int'(bus.done), int'(m_done));
      check($sformatf("rnd%0d_err", c), int'(bus.err), int'(m_err));
      if (ev) begin
        g = q[0];
        check($sformatf("rnd%0d_gate", c), int'(bus.outGate), g);
        check($sformatf("rnd%0d_in0", c), int'(bus.outIn0), g);
        check($sformatf("rnd%0d_in1", c), int'(bus.outIn1), ref_in1(m_layer, g));
        check($sformatf("rnd%0d_add", c), int'(bus.outIsAdd), exp_add(m_layer));
        check($sformatf("rnd%0d_mul", c), int'(bus.outIsMul), exp_mul(m_layer));
        check($sformatf("rnd%0d_last", c), int'(bus.outLast), (g == G - 1) ? 1 : 0);
      end
      s = ($urandom_range(0, 3) == 0);
      l = int'($urandom_range(0, NUM_LAYERS - 1));
      r = ($urandom_range(0, 3) != 0);
      bus.start      = s;
      bus.startLayer = LN_LAYER'(l);
      bus.outReady   = r;
      nd = 1'b0;
      ne = 1'b0;
      if (ev) begin
        if (r) begin
          void'(q.pop_front());
          if (q.size() == 0) nd = 1'b1;
        end
      end else if (!m_done && s) begin
        if (l < NUM_LAYERS - 1) begin
          m_layer = l;
          for (int k = 0; k < G; k++) q.push_back(k);
        end else begin
          ne = 1'b1;
        end
      end
      m_done = nd;
      m_err  = ne;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wiring_enum.md
# wiring_enum

Sequential wiring-predicate enumerator for the CMT sum-check prover/verifier datapath. On a start request for a layer, it streams every gate of that layer as a tuple: gate index, both input-gate indices in the next layer, and gate type. A valid/ready handshake carries the stream. It replaces per-gate combinational add/mul wiring lookups with a single parametrised, back-pressurable source that the sum-check engine consumes one gate per cycle.

## Interface
- `NUM_LAYERS`, default 4: layer count; layer 0 is the output layer and layer NUM_LAYERS-1 is the input layer.
- `LN_G`, default 3: log2 of gates per layer.
- `G`, default 1<<LN_G: gates per layer (derived, not overridden).
- `LN_LAYER`, default $clog2(NUM_LAYERS): layer index width.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: request enumeration of `startLayer`.
- `startLayer` input LN_LAYER: layer to enumerate.
- `busy` output 1: high from the accepted start until `done`.
- `err` output 1: one-cycle pulse when a start names an illegal layer.
- `outValid` output 1: tuple valid.
- `outReady` input 1: consumer accepts the tuple.
- `outGate` output LN_G: current gate index.
- `outIn0` output LN_G: first input gate in layer L+1.
- `outIn1` output LN_G: second input gate in layer L+1.
- `outIsAdd` output 1: gate is additive.
- `outIsMul` output 1: gate is multiplicative.
- `outLast` output 1: tuple is gate G-1.
- `done` output 1: one-cycle pulse after the last handshake.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Requires `start`=1 and `startLayer` < NUM_LAYERS-1.
  - Latches the layer and clears the gate counter to 0.
- IDLE with `start`=1 and `startLayer` ≥ NUM_LAYERS-1:
  - `err` pulses for one cycle.
  - State stays IDLE and no tuple is produced.
- RUN:
  - `outValid`=1.
  - On a handshake (`outValid` & `outReady`), the counter increments.
  - A handshake with `outLast`=1 moves the FSM to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in RUN or DONE is ignored: no `err`, and the latched layer is unchanged.
- Wiring rule for gate g in layer L (butterfly):
  - `outIn0` = g.
  - `outIn1` = g XOR (1 << (L mod LN_G)).
  - Index arithmetic is LN_G bits wide with no carry out.
  - The mod is a compare/subtract on the latched layer, not a divider.
- Gate type: L even → add; L odd → mul (subject to Configuration). Exactly one of `outIsAdd`/`outIsMul` is high while `outValid`=1.
- `outLast` = (counter == G-1). The counter does not wrap inside a run; it is cleared on the next accepted start.
- While `outValid`=1 and `outReady`=0, all `out*` fields hold stable.
- Reset values, applied on any cycle including mid-stream: state IDLE, counter 0, latched layer 0. Every output is 0: `busy`, `err`, `done`, `outValid`, `outGate`, `outIn0`, `outIn1`, `outIsAdd`, `outIsMul`, `outLast`.

## Timing
- All outputs are registered.
- Start accepted at edge t → first tuple (`outValid`=1, `outGate`=0) visible after edge t.
- With `outReady` held high, throughput is one tuple per cycle; G tuples occupy G consecutive cycles.
- `busy` rises with `outValid` at t and falls together with `done`.
- `done` is high in the cycle after the last handshake.
- The earliest next start is accepted in the cycle after `done`. Start-to-next-start minimum is G+2 cycles.
- `err` is high in the cycle after the illegal start is sampled.
- There is no combinational path from `outReady` to any output.

## Configuration
- Macro: `WIRING_MUL_EN`.
- Defined: odd layers are multiplicative (`outIsMul`=1, `outIsAdd`=0); even layers are additive.
- Undefined:
  - Every layer is additive (`outIsAdd`=1 whenever valid).
  - `outIsMul` is tied to 0.
  - The mul-type logic is absent.
  - Wiring indices are unchanged.

## Structure
- Package `cmt_wiring_pkg` holds:
  - FSM state enum `wiring_state_t` {IDLE, RUN, DONE}.
  - Packed struct `wiring_tuple_t` {gate, in0, in1, isAdd, isMul, last}.
  - Function `butterfly_partner(g, layer)`, parametrised on LN_G.
- Sub-module `wiring_rule`: combinational mapping of (layer, gate) → in0, in1, type. It is instantiated once, and its result is registered into the output tuple.

## Test plan
- Bench config: LN_G=3, NUM_LAYERS=4, `WIRING_MUL_EN` defined unless noted.
- Layer 0, `outReady`=1:
  - Required: 8 consecutive tuples g=0..7 with `outIn0`=g, `outIn1`=g^1 (1,0,3,2,5,4,7,6), `outIsAdd`=1.
  - `outLast` only on g=7; `done` the next cycle; `busy` low after it.
- Layer 1:
  - Required: `outIn1`=g^2 (2,3,0,1,6,7,4,5), `outIsMul`=1.
  - Rebuilt without `WIRING_MUL_EN`: `outIsAdd`=1, `outIsMul`=0, identical indices.
- Layer 2 with `outReady` low for 3 cycles while g=2 is presented:
  - Required: tuple {2,2,6,add} held stable for those cycles.
  - Stream resumes with g=3; total valid-high cycles = 11.
- `startLayer`=3:
  - Required: `err` one-cycle pulse, `outValid` stays 0, `busy` stays 0.
  - A legal start the next cycle is accepted.
- Reset mid-stream, plus restart:
  - `rst_n`=0 during the g=4 cycle of layer 0: all outputs 0 on the next cycle and no `done`.
  - After reset, a fresh start on layer 1 begins at g=0.
  - A start asserted at g=5 of a layer-0 run is ignored: stream completes unchanged, no `err`.
